// File: rtl/pipe_pkg.sv
// pipe_pkg: shared encodings for the 5-stage MIPS core pipeline control.
//   - forwarding select codes (FWD_RF/E/M/W)
//   - TUSE_NONE marker for operands the D-stage instruction does not read
//   - MD unit busy-FSM state encoding and counter width
package pipe_pkg;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam int unsigned MD_CNT_W = 4;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2
  } md_state_e;

endpackage

// File: rtl/md_busy_fsm.sv
// md_busy_fsm: busy tracker for the multi-cycle HI/LO multiply/divide unit.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   start_mul_i     E-stage instr is mult/multu
//   start_div_i     E-stage instr is div/divu
//   md_busy_o       MD unit occupied, including the start cycle
//   md_done_o       one-cycle pulse on the last busy cycle
// Parameters: MUL_LAT, DIV_LAT (2..15) cycles occupied after leaving E.
module md_busy_fsm
  import pipe_pkg::*;
#(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start_mul_i,
  input  logic start_div_i,
  output logic md_busy_o,
  output logic md_done_o
);

  md_state_e             state_q, state_d;
  logic [MD_CNT_W-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter is loaded with LAT-1 and the busy state is held down to and
  // including cnt==0, giving exactly LAT busy cycles after the start cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      MD_IDLE: begin
        if (start_mul_i) begin
          state_d = MD_MUL;
          cnt_d   = MD_CNT_W'(MUL_LAT - 1);
        end else if (start_div_i) begin
          state_d = MD_DIV;
          cnt_d   = MD_CNT_W'(DIV_LAT - 1);
        end
      end
      MD_MUL, MD_DIV: begin
        if (cnt_q == '0) begin
          state_d = MD_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Reset masks the registered state in the cycle it is asserted.
  assign md_busy_o = (!reset && (state_q != MD_IDLE)) || start_mul_i || start_div_i;
  assign md_done_o = !reset && (state_q != MD_IDLE) && (cnt_q == '0);

  a_no_dual_start : assert property (@(posedge clk) disable iff (reset)
    !(start_mul_i && start_div_i))
    else $error("md_busy_fsm: simultaneous mult and div start");

  a_no_busy_start : assert property (@(posedge clk) disable iff (reset)
    !((state_q != MD_IDLE) && (start_mul_i || start_div_i)))
    else $error("md_busy_fsm: start while MD unit busy");

endmodule

// File: rtl/md_hazard_ctrl.sv
// md_hazard_ctrl: hazard/stall, forwarding and MD sequencing control for the
// 5-stage MIPS core.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   A_rsD/A_rtD, Tuse_rsD/Tuse_rtD   D-stage operand addresses and use times
//   use_mdD                          D instr touches HI/LO or the MD unit
//   RegWrite*/Awrite*/Tnew*          E/M/W writer info
//   A_rsE/A_rtE                      E-stage operand addresses
//   start_mulE/start_divE            E instr starts a mult/div
//   stall, clr_DE                    freeze F/D, bubble into D/E
//   md_busy, md_done                 MD unit status
//   fwd_rsD/fwd_rtD/fwd_rsE/fwd_rtE  forwarding selects
//   stall_cnt, md_stall_cnt          only with `STALL_CNT_EN defined
module md_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A_rsD,
  input  logic [4:0]  A_rtD,
  input  logic [1:0]  Tuse_rsD,
  input  logic [1:0]  Tuse_rtD,
  input  logic        use_mdD,
  input  logic        RegWriteE,
  input  logic [4:0]  AwriteE,
  input  logic [1:0]  TnewE,
  input  logic        RegWriteM,
  input  logic [4:0]  AwriteM,
  input  logic [1:0]  TnewM,
  input  logic        RegWriteW,
  input  logic [4:0]  AwriteW,
  input  logic [4:0]  A_rsE,
  input  logic [4:0]  A_rtE,
  input  logic        start_mulE,
  input  logic        start_divE,
  output logic        stall,
  output logic        clr_DE,
  output logic        md_busy,
  output logic        md_done,
  output logic [1:0]  fwd_rsD,
  output logic [1:0]  fwd_rtD,
  output logic [1:0]  fwd_rsE,
`ifdef STALL_CNT_EN
  output logic [1:0]  fwd_rtE,
  output logic [31:0] stall_cnt,
  output logic [31:0] md_stall_cnt
`else
  output logic [1:0]  fwd_rtE
`endif
);

  function automatic logic hit(input logic [4:0] a, input logic we, input logic [4:0] dst);
    return (a != 5'd0) && we && (dst == a);
  endfunction

  function automatic logic [1:0] fwd_d(input logic [4:0] a);
    if (hit(a, RegWriteE, AwriteE))      return (TnewE == 2'd0) ? FWD_E : FWD_RF;
    else if (hit(a, RegWriteM, AwriteM)) return (TnewM == 2'd0) ? FWD_M : FWD_RF;
    else if (hit(a, RegWriteW, AwriteW)) return FWD_W;
    else                                 return FWD_RF;
  endfunction

  function automatic logic [1:0] fwd_e(input logic [4:0] a);
    if (hit(a, RegWriteM, AwriteM) && (TnewM == 2'd0)) return FWD_M;
    else if (hit(a, RegWriteW, AwriteW))               return FWD_W;
    else                                               return FWD_RF;
  endfunction

  function automatic logic data_hz(input logic [4:0] a, input logic [1:0] tuse);
    return (hit(a, RegWriteE, AwriteE) && (tuse < TnewE)) ||
           (hit(a, RegWriteM, AwriteM) && (tuse < TnewM));
  endfunction

  logic data_stall;
  logic md_stall;

  md_busy_fsm #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_md_fsm (
    .clk         (clk),
    .reset       (reset),
    .start_mul_i (start_mulE),
    .start_div_i (start_divE),
    .md_busy_o   (md_busy),
    .md_done_o   (md_done)
  );

  assign data_stall = data_hz(A_rsD, Tuse_rsD) || data_hz(A_rtD, Tuse_rtD);
  assign md_stall   = use_mdD && md_busy;
  assign stall      = data_stall || md_stall;
  assign clr_DE     = stall;

  assign fwd_rsD = fwd_d(A_rsD);
  assign fwd_rtD = fwd_d(A_rtD);
  assign fwd_rsE = fwd_e(A_rsE);
  assign fwd_rtE = fwd_e(A_rtE);

`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt_q, md_stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q    <= '0;
      md_stall_cnt_q <= '0;
    end else begin
      if (stall)    stall_cnt_q    <= stall_cnt_q + 32'd1;
      if (md_stall) md_stall_cnt_q <= md_stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt    = stall_cnt_q;
  assign md_stall_cnt = md_stall_cnt_q;
`endif

endmodule
